arith_seq_ctrl: RTL and testbench
=================================

ARITH_SEQ_CTRL -- requirements
Module: arith_seq_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports: clk (clock) and rst_n (reset).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  requester presents an operation.
REQ-005 in_ready  output  1  block can accept an operation.
REQ-006 op  input  2  operation: 00 add, 01 subtract, 10 unsigned multiply, 11 reserved.
REQ-007 inputA  input  16  first operand: augend, minuend or multiplicand.
REQ-008 inputB  input  16  second operand: addend, subtrahend or multiplier.
REQ-009 out_valid  output  1  result is valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 result  output  32  add/sub sum (zero-extended) or 32-bit product.
REQ-012 carry  output  1  carry-out c16 of add/sub (sub: 1 = no borrow); 0 for multiply.
REQ-013 overflow  output  1  signed overflow c16^c15 of add/sub; 0 for multiply.
REQ-014 err  output  1  the operation was reserved op 11.

Function
REQ-015 The FSM SHALL use states IDLE, ADDSUB, MUL and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE.
REQ-017 An edge with in_valid=1 and in_ready=1 SHALL capture op, inputA and inputB; operands SHALL NOT be re-sampled until the next capture.
REQ-018 On capture: op 00/01/11 SHALL go to ADDSUB; op 10 SHALL go to MUL with iteration counter = 0.
REQ-019 The block SHALL contain exactly one 16-bit ripple add/sub datapath; all operations SHALL be computed through it.
REQ-020 Add/sub datapath: B operand XOR mode, carry-in = mode; mode=1 for subtract, mode=0 otherwise.
REQ-021 ADDSUB (op 00/01), one cycle: result={16'h0,sum}, carry=c16, overflow=c16^c15, err=0; then DONE.
REQ-022 ADDSUB (op 11), one cycle: result=0, carry=0, overflow=0, err=1; then DONE.
REQ-023 MUL: the product register {hi,lo} SHALL initialise to hi=0, lo=B.
REQ-024 MUL, each cycle: {c,s} = hi + (lo[0] ? A : 0); then {hi,lo} = {c,s,lo} >> 1; counter increments.
REQ-025 MUL SHALL run exactly 16 iterations, then go to DONE with result={hi,lo}, carry=0, overflow=0, err=0.
REQ-026 Latency from capture edge to out_valid: add/sub/reserved 1 cycle; multiply 16 cycles.
REQ-027 In DONE, out_valid=1; result, carry, overflow and err SHALL hold stable while out_ready=0.
REQ-028 An edge in DONE with out_ready=1 SHALL return to IDLE with out_valid=0.
REQ-029 A new capture SHALL be possible no earlier than the cycle after the DONE->IDLE edge.
REQ-030 in_valid outside IDLE SHALL be ignored and SHALL have no effect on state.
REQ-031 out_ready outside DONE SHALL be ignored.
REQ-032 Arithmetic is modulo 2^16 for add/sub and exact for 16x16 multiply (max FFFE0001).

Reset
REQ-033 rst_n=0 SHALL immediately, asynchronously, force IDLE, counter=0, in_ready=1, out_valid=0, result=0, carry=0, overflow=0 and err=0.
REQ-034 Reset during ADDSUB/MUL/DONE SHALL abort the operation with no result; the first edge after deassertion SHALL be able to capture.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
- op=10, A=0003, B=0005 -> out_valid 16 cycles after capture, result=0000000F, carry=0, overflow=0.
- op=10, A=FFFF, B=FFFF -> result=FFFE0001; op=10, A=0000, B=1234 -> result=00000000.
- op=00, A=FFFF, B=0001 -> after 1 cycle, result=00000000, carry=1, overflow=0; op=00, A=7FFF, B=0001 -> result=00008000, overflow=1.
- op=01, A=7FFF, B=FFFF -> result=00008000, carry=0, overflow=1; op=01, A=1234, B=1234 -> result=0, carry=1, overflow=0.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0, in_valid ignored; op=11 -> err=1, result=0.
- Reset asserted at MUL iteration 8 -> all outputs 0 and in_ready=1 at once; next multiply 2*3 -> 00000006.

Source files
------------

// File: rtl/arith_seq_ctrl_if.sv
// Request/response bundle for arith_seq_ctrl: operation capture handshake in,
// result handshake out.
interface arith_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [15:0] inputA;
  logic [15:0] inputB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        carry;
  logic        overflow;
  logic        err;

  modport master (
    output in_valid, op, inputA, inputB, out_ready,
    input  in_ready, out_valid, result, carry, overflow, err
  );

  modport slave (
    input  in_valid, op, inputA, inputB, out_ready,
    output in_ready, out_valid, result, carry, overflow, err
  );
endinterface

// File: rtl/arith_seq_ctrl.sv
// Sequential add/subtract/multiply unit built around a single 16-bit ripple
// adder; multiply is 16-step shift-and-add through that same adder.
module arith_seq_ctrl (
  input  logic              clk,
  input  logic              rst_n,
  arith_seq_ctrl_if.slave   bus
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAddsub = 2'd1;
  localparam logic [1:0] StMul    = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpMul = 2'b10;
  localparam logic [1:0] OpRsv = 2'b11;

  logic [1:0]  state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] a_q, a_d;
  logic [15:0] hi_q, hi_d;
  logic [15:0] lo_q, lo_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
  logic        carry_q, carry_d;
  logic        overflow_q, overflow_d;
  logic        err_q, err_d;

  // Shared ripple adder operands; lo_q doubles as the B register for add/sub.
  logic [15:0] add_a, add_b, add_bx, sum;
  logic        mode, cy, c15, c16;

  always_comb begin
    add_a = a_q;
    add_b = lo_q;
    mode  = 1'b0;
    if (state_q == StMul) begin
      add_a = hi_q;
      add_b = lo_q[0] ? a_q : 16'h0;
    end else begin
      mode = (op_q == OpSub);
    end
    add_bx = add_b ^ {16{mode}};
    cy     = mode;
    c15    = 1'b0;
    sum    = '0;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) c15 = cy;
      sum[i] = add_a[i] ^ add_bx[i] ^ cy;
      cy     = (add_a[i] & add_bx[i]) | (cy & (add_a[i] ^ add_bx[i]));
    end
    c16 = cy;
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    err_d      = err_q;

    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          op_d    = bus.op;
          a_d     = bus.inputA;
          lo_d    = bus.inputB;
          hi_d    = 16'h0;
          cnt_d   = 4'd0;
          state_d = (bus.op == OpMul) ? StMul : StAddsub;
        end
      end
      StAddsub: begin
        if (op_q == OpRsv) begin
          result_d   = 32'h0;
          carry_d    = 1'b0;
          overflow_d = 1'b0;
          err_d      = 1'b1;
        end else begin
          result_d   = {16'h0, sum};
          carry_d    = c16;
          overflow_d = c16 ^ c15;
          err_d      = 1'b0;
        end
        state_d = StDone;
      end
      StMul: begin
        hi_d  = {c16, sum[15:1]};
        lo_d  = {sum[0], lo_q[15:1]};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          result_d   = {c16, sum[15:1], sum[0], lo_q[15:1]};
          carry_d    = 1'b0;
          overflow_d = 1'b0;
          err_d      = 1'b0;
          state_d    = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      op_q       <= OpAdd;
      a_q        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      err_q      <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.result    = result_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = overflow_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_arith_seq_ctrl.sv
// Directed plus randomized bench for arith_seq_ctrl against an arithmetic
// reference model.
module tb_arith_seq_ctrl;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  arith_seq_ctrl_if bus ();

  arith_seq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                       output logic [31:0] r, output logic cy, output logic ov,
                       output logic er, output int lat);
    logic [16:0] s;
    r = 32'h0; cy = 1'b0; ov = 1'b0; er = 1'b0; lat = 1;
    case (o)
      2'b00: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = {16'h0, s[15:0]};
        cy = s[16];
        ov = (a[15] == b[15]) && (s[15] != a[15]);
      end
      2'b01: begin
        s  = {1'b0, a} - {1'b0, b};
        r  = {16'h0, s[15:0]};
        cy = (a >= b);
        ov = (a[15] != b[15]) && (s[15] != a[15]);
      end
      2'b10: begin
        r   = {16'h0, a} * {16'h0, b};
        lat = 16;
      end
      default: er = 1'b1;
    endcase
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] r, input logic cy,
                               input logic ov, input logic er);
    chk({tag, ".result"}, bus.result, r);
    chk({tag, ".carry"}, {31'h0, bus.carry}, {31'h0, cy});
    chk({tag, ".overflow"}, {31'h0, bus.overflow}, {31'h0, ov});
    chk({tag, ".err"}, {31'h0, bus.err}, {31'h0, er});
  endtask

  // One transaction: capture, wait for out_valid (noise on in_valid/out_ready
  // while busy), optional stall in DONE, then release.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] a,
                        input logic [15:0] b, input int stall, input bit noise);
    logic [31:0] r;
    logic        cy, ov, er;
    int          lat, seen;
    model(o, a, b, r, cy, ov, er, lat);
    @(negedge clk);
    chk({tag, ".in_ready_idle"}, {31'h0, bus.in_ready}, 32'h1);
    bus.in_valid = 1'b1; bus.op = o; bus.inputA = a; bus.inputB = b;
    @(posedge clk); #1;
    seen = 0;
    bus.in_valid = 1'b0;
    while (seen < 40) begin
      if (noise) begin
        bus.in_valid  = 1'($urandom);
        bus.op        = 2'($urandom);
        bus.inputA    = 16'($urandom);
        bus.inputB    = 16'($urandom);
        bus.out_ready = 1'($urandom);
      end
      @(posedge clk); #1;
      seen++;
      if (bus.out_valid) break;
    end
    bus.out_ready = 1'b0;
    chk({tag, ".latency"}, seen, lat);
    check_outputs(tag, r, cy, ov, er);
    for (int i = 0; i < stall; i++) begin
      bus.in_valid = 1'b1;
      bus.inputA   = 16'($urandom);
      @(posedge clk); #1;
      chk({tag, ".stall_valid"}, {31'h0, bus.out_valid}, 32'h1);
      chk({tag, ".stall_in_ready"}, {31'h0, bus.in_ready}, 32'h0);
      check_outputs({tag, ".stall"}, r, cy, ov, er);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, ".release_valid"}, {31'h0, bus.out_valid}, 32'h0);
    chk({tag, ".release_ready"}, {31'h0, bus.in_ready}, 32'h1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.in_valid = 1'b0; bus.op = 2'b00; bus.inputA = '0; bus.inputB = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("reset.in_ready", {31'h0, bus.in_ready}, 32'h1);
    chk("reset.out_valid", {31'h0, bus.out_valid}, 32'h0);
    check_outputs("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    run_op("mul_3x5",    2'b10, 16'h0003, 16'h0005, 0, 1'b0);
    run_op("mul_ffxff",  2'b10, 16'hFFFF, 16'hFFFF, 0, 1'b0);
    run_op("mul_0",      2'b10, 16'h0000, 16'h1234, 0, 1'b0);
    run_op("add_wrap",   2'b00, 16'hFFFF, 16'h0001, 0, 1'b0);
    run_op("add_ovf",    2'b00, 16'h7FFF, 16'h0001, 0, 1'b0);
    run_op("sub_ovf",    2'b01, 16'h7FFF, 16'hFFFF, 0, 1'b0);
    run_op("sub_eq",     2'b01, 16'h1234, 16'h1234, 0, 1'b0);
    run_op("bp_add",     2'b00, 16'h1111, 16'h2222, 5, 1'b1);
    run_op("reserved",   2'b11, 16'hABCD, 16'h1234, 5, 1'b0);

    // Abort a multiply mid-run with an asynchronous reset.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = 2'b10; bus.inputA = 16'h00FF; bus.inputB = 16'h00FF;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort.in_ready", {31'h0, bus.in_ready}, 32'h1);
    chk("abort.out_valid", {31'h0, bus.out_valid}, 32'h0);
    check_outputs("abort", 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    run_op("mul_after_rst", 2'b10, 16'h0002, 16'h0003, 0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      run_op($sformatf("rand%0d", n), 2'($urandom), 16'($urandom), 16'($urandom),
             int'($urandom_range(0, 3)), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
